// File: rtl/mpt_pkg.sv
// Purpose: shared types and constants for the MPT walker pipeline stages.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mpt_pkg;

    localparam int MPT_ADDR_W = 32;
    localparam int PAGE_SHIFT = 12;
    localparam int L1_IDX_LSB = 22;
    localparam int L0_IDX_LSB = 12;

    localparam logic [1:0] ACC_READ  = 2'd0;
    localparam logic [1:0] ACC_WRITE = 2'd1;
    localparam logic [1:0] ACC_EXEC  = 2'd2;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'd0,
        FAULT_INVALID = 2'd1,
        FAULT_PERM    = 2'd2,
        FAULT_DEPTH   = 2'd3
    } mpt_fault_e;

    // One MPT table entry as it comes back from memory.
    typedef struct packed {
        logic [19:0] ppn;
        logic [6:0]  rsvd;
        logic        l;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } mpt_entry_t;

    // Walker transaction: spa = address of the entry just read, rpa = the
    // entry data, mmpt = the physical address being checked.
    typedef struct packed {
        logic [MPT_ADDR_W-1:0] spa;
        logic [31:0]           rpa;
        logic [MPT_ADDR_W-1:0] mmpt;
        logic [1:0]            access_type;
        logic                  walking;
    } mptw_transaction_t;

    typedef struct packed {
        logic                  allow;
        mpt_fault_e            fault;
        logic [MPT_ADDR_W-1:0] pa;
    } mpt_resp_t;

    localparam int MPTW_TXN_W = $bits(mptw_transaction_t);

    // Reserved access type (3) never matches a permission bit.
    function automatic logic perm_ok(input mpt_entry_t e, input logic [1:0] acc);
        logic ok;
        ok = 1'b0;
        case (acc)
            ACC_READ:  ok = e.r;
            ACC_WRITE: ok = e.w;
            ACC_EXEC:  ok = e.x;
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mpt_out_buffer.sv
// Purpose: single-entry valid/ready output register, generic over the payload type.
// Latency: one cycle from input handshake to out_valid.
// Backpressure: in_ready = empty, or full and draining this cycle (full throughput).
// Ports: clk_i/rst_i; in_valid/in_ready/in_data upstream; out_valid/out_ready/out_data downstream.
module mpt_out_buffer #(
    parameter type dtype = logic [31:0]
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_valid,
    output logic in_ready,
    input  dtype in_data,
    output logic out_valid,
    input  logic out_ready,
    output dtype out_data
);

    logic vld_q, vld_d;
    dtype dat_q, dat_d;

    // in_ready does not look at in_valid, so upstream may use it to steer.
    assign in_ready  = !vld_q || out_ready;
    assign out_valid = vld_q;
    assign out_data  = dat_q;

    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (vld_q && out_ready) begin
            vld_d = 1'b0;
        end
        if (in_valid && in_ready) begin
            vld_d = 1'b1;
            dat_d = in_data;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

endmodule

// File: rtl/mpt_entry_check_stage.sv
// Purpose: decode a fetched MPT entry and route the walk to a final response or a next-level walk.
// Latency: one cycle from input handshake to the chosen output's valid.
// Backpressure: input stalls only when the buffer its data routes to is full and not draining.
// Ports: stage_slave_* from memory read stage; walk_master_* next-level walk request;
//        resp_* permission response (allow, fault code, checked PA); fault_count_o saturating fault count.
module mpt_entry_check_stage
    import mpt_pkg::*;
#(
    parameter int PIPELINE_SLAVE_DATA_WIDTH  = MPTW_TXN_W,  // must equal $bits(mptw_transaction_t)
    parameter int PIPELINE_MASTER_DATA_WIDTH = MPTW_TXN_W,  // must equal $bits(mptw_transaction_t)
    parameter int ADDR_WIDTH                 = MPT_ADDR_W,
    parameter int FAULT_CNT_WIDTH            = 16
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  stage_slave_data,
    input  logic                                  stage_slave_valid,
    output logic                                  stage_slave_ready,
    output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] walk_master_data,
    output logic                                  walk_master_valid,
    input  logic                                  walk_master_ready,
    output logic                                  resp_valid_o,
    input  logic                                  resp_ready_i,
    output logic                                  resp_allow_o,
    output logic [1:0]                            resp_fault_o,
    output logic [ADDR_WIDTH-1:0]                 resp_pa_o,
    output logic [FAULT_CNT_WIDTH-1:0]            fault_count_o
);

    mptw_transaction_t in_txn;
    mpt_entry_t        entry;
    logic              route_walk;
    mpt_resp_t         resp_in;
    mptw_transaction_t walk_in;

    logic              walk_in_ready;
    logic              resp_in_ready;
    mptw_transaction_t walk_out;
    mpt_resp_t         resp_out;

    logic [FAULT_CNT_WIDTH-1:0] fault_cnt_q, fault_cnt_d;

    assign in_txn = stage_slave_data;
    assign entry  = in_txn.rpa;

    // Routing decision; first matching rule wins.
    always_comb begin
        route_walk    = 1'b0;
        resp_in       = '0;
        resp_in.pa    = in_txn.mmpt;
        resp_in.fault = FAULT_NONE;
        walk_in       = in_txn;
        walk_in.walking = 1'b0;
        walk_in.rpa     = '0;
        // Next-level entry address: table base from PPN plus the 4-byte
        // entry selected by the level-0 index of the checked PA. Wraps.
        walk_in.spa = {entry.ppn, {PAGE_SHIFT{1'b0}}}
                    + MPT_ADDR_W'({in_txn.mmpt[L1_IDX_LSB-1:L0_IDX_LSB], 2'b00});

        if (!entry.v) begin
            resp_in.fault = FAULT_INVALID;
        end else if (entry.l) begin
            resp_in.allow = perm_ok(entry, in_txn.access_type);
            resp_in.fault = resp_in.allow ? FAULT_NONE : FAULT_PERM;
        end else if (!in_txn.walking) begin
            // Pointer entry found at the last level: walk is too deep.
            resp_in.fault = FAULT_DEPTH;
        end else begin
            route_walk = 1'b1;
        end
    end

    // Ready follows the buffer this data would land in, so a stalled
    // output never blocks traffic bound for the other one.
    assign stage_slave_ready = route_walk ? walk_in_ready : resp_in_ready;

    mpt_out_buffer #(.dtype(mptw_transaction_t)) u_walk_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (stage_slave_valid && route_walk),
        .in_ready  (walk_in_ready),
        .in_data   (walk_in),
        .out_valid (walk_master_valid),
        .out_ready (walk_master_ready),
        .out_data  (walk_out)
    );

    mpt_out_buffer #(.dtype(mpt_resp_t)) u_resp_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_valid  (stage_slave_valid && !route_walk),
        .in_ready  (resp_in_ready),
        .in_data   (resp_in),
        .out_valid (resp_valid_o),
        .out_ready (resp_ready_i),
        .out_data  (resp_out)
    );

    assign walk_master_data = walk_out;
    assign resp_allow_o     = resp_out.allow;
    assign resp_fault_o     = resp_out.fault;
    assign resp_pa_o        = resp_out.pa;

    // Counted at input acceptance, not at response drain.
    always_comb begin
        fault_cnt_d = fault_cnt_q;
        if (stage_slave_valid && stage_slave_ready && !route_walk
                && resp_in.fault != FAULT_NONE && fault_cnt_q != '1) begin
            fault_cnt_d = fault_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fault_cnt_q <= '0;
        end else begin
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign fault_count_o = fault_cnt_q;

    // Fields deliberately not consumed by this stage.
    logic unused_fields;
    assign unused_fields = ^{entry.rsvd, in_txn.spa};

endmodule
